// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: button indices, arbiter FSM states and the
// winner-search helper used by btn_event_arbiter.
package cpu_pkg;

  localparam int NUM_BTNS = 4;
  localparam int BTN_PUSH = 3;
  localparam int BTN_POP  = 2;
  localparam int BTN_ADD  = 1;
  localparam int BTN_MULT = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Walk downward from 'start' (wrapping 0 -> 3) and return the first set bit.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      cand = start - 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: SYNC_STAGES-deep synchronizer followed by a tick-sampled
// debouncer. 'rise' pulses for one cycle when the debounced level goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic tick_ms,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = rise_reg;

  // Synchronizer chain; nothing downstream sees btn_raw directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Accept a new level only after DEBOUNCE_TICKS consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (tick_ms) begin
        if (sync_out == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == 4'(DEBOUNCE_TICKS - 1)) begin
          cnt_reg   <= '0;
          level_reg <= sync_out;
          rise_reg  <= sync_out;
        end else begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces four pushbuttons, latches presses as pending events and grants
// them one at a time to the CPU, holding each grant until evt_ack.
// Build option: define BTN_EVENT_RR_EN for round-robin arbitration instead of
// fixed priority (PUSH > POP > ADD > MULT).
module btn_event_arbiter
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_in,
  input  logic       tick_ms,
  input  logic       evt_ack,
  output logic [3:0] evt_req,
  output logic       evt_valid,
  output logic [3:0] pending,
  output logic [3:0] overrun
);

  logic [3:0] rise;
  logic [3:0] clr;
  logic [1:0] search_start;

  arb_state_e state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [3:0] evt_req_reg, evt_req_next;
  logic       evt_valid_reg, evt_valid_next;
  logic [3:0] pending_reg, pending_next;
  logic [3:0] overrun_reg, overrun_next;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .SYNC_STAGES   (SYNC_STAGES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_in[gi]),
        .tick_ms(tick_ms),
        .rise   (rise[gi])
      );
    end
  endgenerate

`ifdef BTN_EVENT_RR_EN
  logic [1:0] rr_ptr_reg, rr_ptr_next;

  // Search starts just below the last acknowledged button.
  assign search_start = rr_ptr_reg - 2'd1;
  assign rr_ptr_next  = (state_reg == GRANT && evt_ack) ? idx_reg : rr_ptr_reg;

  // Round-robin pointer moves only when the CPU takes an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 2'(BTN_MULT);
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  assign search_start = 2'(BTN_PUSH);
`endif

  // Next-state, grant and pending/overrun bookkeeping.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clr        = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (pending_reg != 4'b0000) begin
          idx_next   = pick_winner(pending_reg, search_start);
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (evt_ack) begin
          clr        = 4'b0001 << idx_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    evt_valid_next = (state_next == GRANT);
    evt_req_next   = evt_valid_next ? (4'b0001 << idx_next) : 4'b0000;
    // A new press wins over a same-cycle ack clear.
    pending_next   = (pending_reg & ~clr) | rise;
    overrun_next   = overrun_reg | (rise & pending_reg & ~clr);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      evt_req_reg   <= 4'b0000;
      evt_valid_reg <= 1'b0;
      pending_reg   <= 4'b0000;
      overrun_reg   <= 4'b0000;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      evt_req_reg   <= evt_req_next;
      evt_valid_reg <= evt_valid_next;
      pending_reg   <= pending_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign evt_req   = evt_req_reg;
  assign evt_valid = evt_valid_reg;
  assign pending   = pending_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: expected grants go into a queue,
// a negedge monitor pops and compares each new grant.
module tb_btn_event_arbiter;

  localparam int DT = 4;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic       tick_ms;
  logic       evt_ack;
  logic [3:0] evt_req;
  logic       evt_valid;
  logic [3:0] pending;
  logic [3:0] overrun;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  btn_event_arbiter #(
    .DEBOUNCE_TICKS(DT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .tick_ms  (tick_ms),
    .evt_ack  (evt_ack),
    .evt_req  (evt_req),
    .evt_valid(evt_valid),
    .pending  (pending),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_ms = 1'b1;
    cyc(1);
    tick_ms = 1'b0;
    cyc(1);
  endtask

  task automatic debounce(input logic [3:0] m);
    btn_in = m;
    cyc(3);
    repeat (DT) tick();
  endtask

  task automatic ack();
    evt_ack = 1'b1;
    cyc(1);
    evt_ack = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end else begin
      $display("ok   %s = %b", nm, act);
    end
  endtask

  task automatic two_way(input logic [3:0] first, input logic [3:0] second);
    exp_q.push_back(first);
    exp_q.push_back(second);
    debounce(first | second);
    chk("both_pending", pending, first | second);
    cyc(1);
    chk("first_grant", evt_req, first);
    ack();
    chk("after_first_ack_pending", pending, second);
    chk("after_first_ack_valid", {3'b0, evt_valid}, 4'b0000);
    cyc(1);
    chk("second_grant", evt_req, second);
    ack();
    chk("after_second_ack_pending", pending, 4'b0000);
    debounce(4'b0000);
  endtask

  // Scoreboard monitor: every new grant must match the oldest expectation.
  initial begin
    logic       prev_valid;
    logic [3:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (evt_valid && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant actual=%b required=none", evt_req);
        end else begin
          e = exp_q.pop_front();
          if (evt_req !== e) begin
            failures++;
            $display("FAIL grant_order actual=%b required=%b", evt_req, e);
          end else begin
            $display("ok   grant %b", evt_req);
          end
        end
      end
      prev_valid = evt_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    btn_in  = 4'b0000;
    tick_ms = 1'b0;
    evt_ack = 1'b0;
    reset   = 1'b1;
    cyc(3);
    chk("reset_evt_req", evt_req, 4'b0000);
    chk("reset_valid", {3'b0, evt_valid}, 4'b0000);
    chk("reset_pending", pending, 4'b0000);
    chk("reset_overrun", overrun, 4'b0000);
    reset = 1'b0;
    cyc(2);

    // Single PUSH press; ack while still IDLE must be ignored.
    exp_q.push_back(4'b1000);
    debounce(4'b1000);
    chk("push_pending", pending, 4'b1000);
    chk("push_valid_not_yet", {3'b0, evt_valid}, 4'b0000);
    evt_ack = 1'b1;
    cyc(1);
    evt_ack = 1'b0;
    chk("push_grant", evt_req, 4'b1000);
    chk("push_valid", {3'b0, evt_valid}, 4'b0001);
    chk("idle_ack_ignored", pending, 4'b1000);
    ack();
    chk("push_ack_pending", pending, 4'b0000);
    chk("push_ack_valid", {3'b0, evt_valid}, 4'b0000);
    debounce(4'b0000);
    chk("release_no_event", pending, 4'b0000);

    // Short press: only DT-1 ticks high.
    btn_in = 4'b1000;
    cyc(3);
    repeat (DT - 1) tick();
    btn_in = 4'b0000;
    cyc(3);
    repeat (DT) tick();
    chk("short_pending", pending, 4'b0000);
    chk("short_valid", {3'b0, evt_valid}, 4'b0000);

    // POP and MULT together.
    two_way(4'b0100, 4'b0001);

    // Make POP the most recent grant, then race POP and MULT again.
    exp_q.push_back(4'b0100);
    debounce(4'b0100);
    cyc(1);
    chk("pop_grant", evt_req, 4'b0100);
    ack();
    debounce(4'b0000);
`ifdef BTN_EVENT_RR_EN
    two_way(4'b0001, 4'b0100);
`else
    two_way(4'b0100, 4'b0001);
`endif

    // ADD granted, then a new ADD press lands with the ack.
    exp_q.push_back(4'b0010);
    debounce(4'b0010);
    cyc(1);
    chk("add_grant", evt_req, 4'b0010);
    debounce(4'b0000);
    btn_in = 4'b0010;
    cyc(3);
    repeat (DT - 1) tick();
    tick_ms = 1'b1;
    cyc(1);
    tick_ms = 1'b0;
    evt_ack = 1'b1;
    exp_q.push_back(4'b0010);
    cyc(1);
    evt_ack = 1'b0;
    chk("coincide_pending", pending, 4'b0010);
    chk("coincide_overrun", overrun, 4'b0000);
    cyc(1);
    chk("add_regrant", evt_req, 4'b0010);

    // Second ADD press with no ack: overrun, still one grant.
    debounce(4'b0000);
    debounce(4'b0010);
    chk("overrun_set", overrun, 4'b0010);
    chk("overrun_pending", pending, 4'b0010);
    chk("overrun_grant_held", evt_req, 4'b0010);
    ack();
    chk("overrun_ack_pending", pending, 4'b0000);
    chk("overrun_sticky", overrun, 4'b0010);
    cyc(2);
    chk("overrun_single_grant", {3'b0, evt_valid}, 4'b0000);
    debounce(4'b0000);

    // Reset mid-grant with PUSH and ADD held.
    exp_q.push_back(4'b1000);
    debounce(4'b1010);
    chk("pre_reset_pending", pending, 4'b1010);
    cyc(1);
    chk("pre_reset_grant", evt_req, 4'b1000);
    reset = 1'b1;
    cyc(1);
    chk("midreset_evt_req", evt_req, 4'b0000);
    chk("midreset_valid", {3'b0, evt_valid}, 4'b0000);
    chk("midreset_pending", pending, 4'b0000);
    chk("midreset_overrun", overrun, 4'b0000);
    reset = 1'b0;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    cyc(3);
    repeat (DT) tick();
    chk("held_repending", pending, 4'b1010);
    cyc(1);
    chk("held_regrant", evt_req, 4'b1000);
    ack();
    chk("held_ack_pending", pending, 4'b0010);
    cyc(1);
    chk("held_second_grant", evt_req, 4'b0010);
    ack();
    chk("held_final_pending", pending, 4'b0000);
    debounce(4'b0000);

    cyc(5);
    chk("queue_empty", 4'(exp_q.size()), 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
